// File: rtl/disp_pkg.sv
//------------------------------------------------------------------------------
// disp_pkg : mode encodings, blank glyph and FSM state type for disp_base_conv
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package disp_pkg;

  localparam logic [1:0] MODE_DEC = 2'b00;
  localparam logic [1:0] MODE_HEX = 2'b01;
  localparam logic [1:0] MODE_OCT = 2'b10;
  localparam logic [1:0] MODE_OFF = 2'b11;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEC_SHIFT = 2'd1,
    LOAD      = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_encode.sv
//------------------------------------------------------------------------------
// seg7_encode : 4-bit nibble to active-low 7-segment glyph (0-9, A, b, C, d, E, F)
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg7_encode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // bit 0 = segment a ... bit 6 = segment g, 0 lights the segment
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/disp_base_conv.sv
//------------------------------------------------------------------------------
// disp_base_conv : sequential WIDTH-bit to NDIG-digit dec/hex/oct 7-seg converter
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module disp_base_conv
  import disp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  value,
  input  logic              blank_lz,
  output logic              busy,
  output logic              done,
  output logic [NDIG*7-1:0] seg
);

  localparam int BCD_W    = NDIG * 4;
  localparam int OCT_W    = NDIG * 3;
  localparam int CNT_W    = $clog2(WIDTH + 1);
  localparam int HEX_DIGS = (WIDTH + 3) / 4;
  localparam int OCT_DIGS = (WIDTH + 2) / 3;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic             r_blank_lz;
  logic [WIDTH-1:0] r_shreg;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;

  logic [BCD_W-1:0]  w_bcd_adj;
  logic [BCD_W-1:0]  w_hex_pad;
  logic [OCT_W-1:0]  w_oct_pad;
  logic [3:0]        w_nib   [NDIG];
  logic [6:0]        w_glyph [NDIG];
  logic [NDIG-1:0]   w_on;
  logic [NDIG-1:0]   w_show;
  logic [NDIG*7-1:0] w_digit;

  always_comb begin
    for (int d = 0; d < NDIG; d++) begin
      w_bcd_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? r_bcd[4*d +: 4] + 4'd3
                                                      : r_bcd[4*d +: 4];
    end
  end

  // Hex/octal read the captured value directly; it is only shifted in decimal mode
  assign w_hex_pad = BCD_W'(r_shreg);
  assign w_oct_pad = OCT_W'(r_shreg);

  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      w_nib[i] = 4'd0;
      w_on[i]  = 1'b0;
      case (r_mode)
        MODE_DEC: begin
          w_nib[i] = r_bcd[4*i +: 4];
          w_on[i]  = 1'b1;
        end
        MODE_HEX: begin
          w_nib[i] = w_hex_pad[4*i +: 4];
          w_on[i]  = (i < HEX_DIGS);
        end
        MODE_OCT: begin
          w_nib[i] = {1'b0, w_oct_pad[3*i +: 3]};
          w_on[i]  = (i < OCT_DIGS);
        end
        default: ;
      endcase
    end
  end

  // A digit survives blanking if it or any digit above it is nonzero; digit 0 always survives
  always_comb begin
    logic v_nz_above;
    v_nz_above = 1'b0;
    w_show     = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      v_nz_above = v_nz_above | (w_nib[i] != 4'd0);
      w_show[i]  = w_on[i] & (~r_blank_lz | v_nz_above | (i == 0));
    end
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    seg7_encode u_enc (
      .nibble (w_nib[g]),
      .seg    (w_glyph[g])
    );
    assign w_digit[7*g +: 7] = w_show[g] ? w_glyph[g] : SEG_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      seg        <= {NDIG{SEG_OFF}};
      r_mode     <= MODE_OFF;
      r_blank_lz <= 1'b0;
      r_shreg    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode     <= mode;
            r_blank_lz <= blank_lz;
            r_shreg    <= value;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(WIDTH);
            busy       <= 1'b1;
            r_state    <= (mode == MODE_DEC) ? DEC_SHIFT : LOAD;
          end
        end
        DEC_SHIFT: begin
          r_bcd   <= {w_bcd_adj[BCD_W-2:0], r_shreg[WIDTH-1]};
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= LOAD;
        end
        LOAD: begin
          seg     <= w_digit;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_disp_base_conv.sv
//------------------------------------------------------------------------------
// tb_disp_base_conv : directed + randomized check of disp_base_conv against a digit model
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_disp_base_conv;

  localparam int WIDTH = 8;
  localparam int NDIG  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  value;
  logic              blank_lz;
  logic              busy;
  logic              done;
  logic [NDIG*7-1:0] seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_base_conv #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .value    (value),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .seg      (seg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[d];
  endfunction

  // Digits from plain arithmetic, then leading-zero blanking above the top nonzero digit
  function automatic logic [NDIG*7-1:0] model(input logic [1:0] m, input int v, input logic blz);
    int dig [NDIG];
    bit on  [NDIG];
    int msd;
    logic [NDIG*7-1:0] res;
    for (int i = 0; i < NDIG; i++) begin
      dig[i] = 0;
      on[i]  = 0;
      case (m)
        2'b00: begin dig[i] = (v / (10 ** i)) % 10; on[i] = 1; end
        2'b01: begin dig[i] = (v >> (4 * i)) & 15;  on[i] = (4 * i < WIDTH); end
        2'b10: begin dig[i] = (v >> (3 * i)) & 7;   on[i] = (3 * i < WIDTH); end
        default: ;
      endcase
    end
    msd = 0;
    for (int i = 0; i < NDIG; i++) if (on[i] && dig[i] != 0) msd = i;
    for (int i = 0; i < NDIG; i++)
      res[7*i +: 7] = (on[i] && !(blz && i > msd)) ? glyph(dig[i]) : 7'h7F;
    return res;
  endfunction

  task automatic launch(input logic [1:0] m, input int v, input logic blz, input bit sync);
    if (sync) @(negedge clk);
    start    = 1'b1;
    mode     = m;
    value    = WIDTH'(v);
    blank_lz = blz;
    @(posedge clk);
    #1;
    start    = 1'b0;
    mode     = 2'($urandom);
    value    = WIDTH'($urandom);
    blank_lz = 1'($urandom);
    check("busy_on", busy, 1);
  endtask

  // Called 1 time unit after the accepting edge; inject_at > 0 pulses a hex start mid-flight
  task automatic finish_conv(input logic [1:0] m, input logic [NDIG*7-1:0] exp_seg,
                             input int inject_at);
    int n;
    bit got;
    n   = 0;
    got = 0;
    while (n < 40 && !got) begin
      if (inject_at != 0 && n == inject_at) begin
        start = 1'b1;
        mode  = 2'b01;
        value = 8'h3C;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) got = 1;
    end
    check("latency", n, (m == 2'b00) ? WIDTH + 1 : 1);
    if (got) begin
      check("seg", seg, exp_seg);
      check("busy_off", busy, 0);
    end
  endtask

  initial begin
    int done_seen;
    logic [1:0] m;
    int v;
    logic blz;

    rst = 1'b1; start = 1'b0; mode = 2'b00; value = '0; blank_lz = 1'b0;
    #1;
    check("rst_seg", seg, 21'h1FFFFF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    launch(2'b00, 255, 0, 1);
    finish_conv(2'b00, {7'h24, 7'h12, 7'h12}, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);

    launch(2'b01, 8'hA7, 0, 1);
    finish_conv(2'b01, {7'h7F, 7'h08, 7'h78}, 0);

    launch(2'b10, 8'hC7, 0, 1);
    finish_conv(2'b10, {7'h30, 7'h40, 7'h78}, 0);

    launch(2'b00, 5, 1, 1);
    finish_conv(2'b00, {7'h7F, 7'h7F, 7'h12}, 0);
    launch(2'b00, 0, 1, 1);
    finish_conv(2'b00, {7'h7F, 7'h7F, 7'h40}, 0);
    launch(2'b00, 105, 1, 1);
    finish_conv(2'b00, {7'h79, 7'h40, 7'h12}, 0);

    launch(2'b11, 8'h5A, 0, 1);
    finish_conv(2'b11, 21'h1FFFFF, 0);

    // Async reset while idle with a non-blank display
    launch(2'b01, 8'h12, 0, 1);
    finish_conv(2'b01, model(2'b01, 8'h12, 0), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("idle_rst_seg", seg, 21'h1FFFFF);
    check("idle_rst_busy", busy, 0);
    check("idle_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Start while busy is ignored
    launch(2'b00, 200, 0, 1);
    finish_conv(2'b00, {7'h24, 7'h40, 7'h40}, 3);
    repeat (3) begin
      @(posedge clk); #1;
      check("ignored_start", {30'd0, busy, done}, 0);
    end

    // Reset in the middle of a decimal conversion
    launch(2'b00, 77, 0, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_seg", seg, 21'h1FFFFF);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    launch(2'b01, 8'h4E, 0, 1);
    finish_conv(2'b01, model(2'b01, 8'h4E, 0), 0);

    // Back-to-back: new start presented during the done cycle
    launch(2'b00, 99, 0, 0);
    finish_conv(2'b00, model(2'b00, 99, 0), 0);
    launch(2'b10, 8'hFF, 1, 0);
    finish_conv(2'b10, model(2'b10, 8'hFF, 1), 0);

    for (int k = 0; k < 40; k++) begin
      m   = 2'($urandom_range(0, 3));
      v   = $urandom_range(0, 255);
      blz = 1'($urandom_range(0, 1));
      launch(m, v, blz, bit'($urandom_range(0, 1)));
      finish_conv(m, model(m, v, blz), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
